// File: rtl/tx_logic.sv
// tx_logic: router output-side transmitter.
// Pops a show-ahead buffer, picks an XY-routed output direction (X first) from
// the item header and presents the item on exactly one of N/S/E/W/L through a
// single-entry staging register that sustains one item per cycle.
// Optional feature macro: TX_PKT_COUNT_EN adds a saturating 16-bit
// departure counter on port sent_count.
module tx_logic #(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 2,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [SIZE-1:0] item_in,
  output logic            read,
  output logic            n_valid,
  input  logic            n_read,
  output logic [SIZE-1:0] n_item,
  output logic            s_valid,
  input  logic            s_read,
  output logic [SIZE-1:0] s_item,
  output logic            e_valid,
  input  logic            e_read,
  output logic [SIZE-1:0] e_item,
  output logic            w_valid,
  input  logic            w_read,
  output logic [SIZE-1:0] w_item,
  output logic            l_valid,
  input  logic            l_read,
  output logic [SIZE-1:0] l_item
`ifdef TX_PKT_COUNT_EN
  ,
  output logic [15:0]     sent_count
`endif
);

  // One-hot direction bit positions
  localparam int unsigned DN = 0;
  localparam int unsigned DS = 1;
  localparam int unsigned DE = 2;
  localparam int unsigned DW = 3;
  localparam int unsigned DL = 4;

  localparam logic [ADDR_W-1:0] MY_X_C = ADDR_W'(MY_X);
  localparam logic [ADDR_W-1:0] MY_Y_C = ADDR_W'(MY_Y);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [SIZE-1:0]   hold_item;
  logic [4:0]        hold_dir;
  logic [4:0]        in_dir;
  logic [4:0]        port_read;
  logic [ADDR_W-1:0] dx;
  logic [ADDR_W-1:0] dy;
  logic              departure;

  assign dx = item_in[SIZE-1 -: ADDR_W];
  assign dy = item_in[SIZE-1-ADDR_W -: ADDR_W];

  // XY routing of the head-of-buffer item, X resolved first
  always_comb begin
    in_dir = '0;
    if (dx > MY_X_C)      in_dir[DE] = 1'b1;
    else if (dx < MY_X_C) in_dir[DW] = 1'b1;
    else if (dy > MY_Y_C) in_dir[DS] = 1'b1;
    else if (dy < MY_Y_C) in_dir[DN] = 1'b1;
    else                  in_dir[DL] = 1'b1;
  end

  assign port_read = {l_read, w_read, e_read, s_read, n_read};

  // Departure only counts the consumer of the port the held item is routed to
  always_comb begin
    departure = (state == BUSY) && ((hold_dir & port_read) != '0);
    read      = !reset && !empty && ((state == IDLE) || departure);
  end

  // Staging register FSM: load when free or when the held item leaves
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_item <= '0;
      hold_dir  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            hold_item <= item_in;
            hold_dir  <= in_dir;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (departure) begin
            if (read) begin
              hold_item <= item_in;
              hold_dir  <= in_dir;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign n_valid = (state == BUSY) && hold_dir[DN];
  assign s_valid = (state == BUSY) && hold_dir[DS];
  assign e_valid = (state == BUSY) && hold_dir[DE];
  assign w_valid = (state == BUSY) && hold_dir[DW];
  assign l_valid = (state == BUSY) && hold_dir[DL];

  assign n_item = hold_item;
  assign s_item = hold_item;
  assign e_item = hold_item;
  assign w_item = hold_item;
  assign l_item = hold_item;

`ifdef TX_PKT_COUNT_EN
  // Saturating count of items handed to a consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_count <= '0;
    end else if (departure && (sent_count != '1)) begin
      sent_count <= sent_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_logic.sv
// tb_tx_logic: scoreboard bench for tx_logic (SIZE=8, ADDR_W=2, MY_X=1, MY_Y=1).
// A queue models the show-ahead buffer; popped items go to a scoreboard that
// a negedge monitor compares against the DUT's port outputs.
module tb_tx_logic;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty = 1'b1;
  logic [7:0] item_in = '0;
  logic       read;
  logic       n_valid, s_valid, e_valid, w_valid, l_valid;
  logic [7:0] n_item, s_item, e_item, w_item, l_item;
  logic [4:0] rd = '0;  // {l,w,e,s,n} consumer reads
`ifdef TX_PKT_COUNT_EN
  logic [15:0] sent_count;
  int unsigned cnt_model = 0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] buf_q[$];   // buffer contents
  logic [7:0] exp_q[$];   // items popped but not yet departed
  bit         pop_req = 1'b0;
  bit         dep_pend = 1'b0;

  always #5 clk = ~clk;

  tx_logic #(.SIZE(8), .ADDR_W(2), .MY_X(1), .MY_Y(1)) dut (
    .clk(clk), .reset(reset), .empty(empty), .item_in(item_in), .read(read),
    .n_valid(n_valid), .n_read(rd[0]), .n_item(n_item),
    .s_valid(s_valid), .s_read(rd[1]), .s_item(s_item),
    .e_valid(e_valid), .e_read(rd[2]), .e_item(e_item),
    .w_valid(w_valid), .w_read(rd[3]), .w_item(w_item),
    .l_valid(l_valid), .l_read(rd[4]), .l_item(l_item)
`ifdef TX_PKT_COUNT_EN
    , .sent_count(sent_count)
`endif
  );

  // Port index: 0=N 1=S 2=E 3=W 4=L
  function automatic int route(input logic [7:0] it);
    int x, y;
    x = int'(it[7:6]);
    y = int'(it[5:4]);
    if (x > 1) return 2;
    if (x < 1) return 3;
    if (y > 1) return 1;
    if (y < 1) return 0;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Buffer model: move the popped head into the scoreboard, then present the new head
  always @(posedge clk) begin
    if (pop_req && buf_q.size() > 0) exp_q.push_back(buf_q.pop_front());
    #3;
    empty   = (buf_q.size() == 0);
    item_in = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
  end

  // Scoreboard retire / reset discard, plus counter model
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
`ifdef TX_PKT_COUNT_EN
      cnt_model = 0;
`endif
    end else if (dep_pend) begin
      void'(exp_q.pop_front());
`ifdef TX_PKT_COUNT_EN
      if (cnt_model < 32'hFFFF) cnt_model++;
`endif
    end
  end

  // Monitor: compare presented port/item and pop strobe against the model
  always @(negedge clk) begin
    logic [4:0] exp_v, act_v;
    logic [7:0] items[5];
    bit dep, exp_rd;
    int p;
    act_v = {l_valid, w_valid, e_valid, s_valid, n_valid};
    items = '{n_item, s_item, e_item, w_item, l_item};
    exp_v = '0;
    p = 0;
    if (exp_q.size() > 0) begin
      p = route(exp_q[0]);
      exp_v[p] = 1'b1;
    end
    chk("valids", 32'(act_v), 32'(exp_v));
    if (exp_q.size() > 0) chk("item", 32'(items[p]), 32'(exp_q[0]));
    dep    = (exp_q.size() > 0) && rd[p];
    exp_rd = !reset && (buf_q.size() > 0) && ((exp_q.size() == 0) || dep);
    chk("read", 32'(read), 32'(exp_rd));
`ifdef TX_PKT_COUNT_EN
    chk("sent_count", 32'(sent_count), cnt_model);
`endif
    dep_pend = dep && !reset;
    pop_req  = exp_rd;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rd = '1;
    for (int i = 0; i < 50; i++) begin
      if (buf_q.size() == 0 && exp_q.size() == 0) return;
      step();
    end
    chk("drain_timeout", 32'(buf_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] route_items[5];
    bit seen;
    route_items = '{8'hC0, 8'h00, 8'h60, 8'h40, 8'h50};

    // 1. Reset with a waiting item
    reset = 1'b1;
    rd = '0;
    step();
    buf_q.push_back(8'hC5);
    repeat (3) begin
      @(negedge clk);
      chk("reset_read", 32'(read), 32'd0);
      chk("reset_hold_item", 32'(n_item), 32'd0);
    end
    step();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_e_valid", 32'(e_valid), 32'd1);
    chk("post_reset_e_item", 32'(e_item), 32'hC5);
    step();
    drain();

    // 2. Routing of each direction
    rd = '0;
    for (int i = 0; i < 5; i++) begin
      buf_q.push_back(route_items[i]);
      repeat (2) step();
      rd = '1;
      step();
      rd = '0;
    end
    drain();

    // 3. Back-to-back: four queued items, all consumers ready
    rd = '1;
    step();
    for (int i = 0; i < 4; i++) buf_q.push_back(8'(8'h10 * i + 8'h05));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_read", 32'(read), 32'd1);
    end
    @(negedge clk);
    chk("b2b_read_after", 32'(read), 32'd0);
    @(negedge clk);
    chk("b2b_idle", 32'({l_valid, w_valid, e_valid, s_valid, n_valid}), 32'd0);
    step();

    // 4. Stall on east with a stray north read
    rd = 5'b00001;
    buf_q.push_back(8'hC0);
    step();
    buf_q.push_back(8'h00);
    repeat (5) begin
      @(negedge clk);
      chk("stall_e_valid", 32'(e_valid), 32'd1);
      chk("stall_e_item", 32'(e_item), 32'hC0);
      chk("stall_read", 32'(read), 32'd0);
    end
    step();
    rd = '1;
    drain();

    // 5. Reset while west item is held
    rd = '0;
    buf_q.push_back(8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = w_valid;
    end
    chk("wait_w_valid", 32'(seen), 32'd1);
    buf_q.push_back(8'h40);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_read", 32'(read), 32'd0);
    step();
    @(negedge clk);
    chk("midreset_w_valid", 32'(w_valid), 32'd0);
    step();
    reset = 1'b0;
    drain();

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      step();
      rd = 5'($urandom);
      if ($urandom_range(0, 3) != 0 && buf_q.size() < 6) buf_q.push_back(8'($urandom));
      reset = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    drain();

`ifdef TX_PKT_COUNT_EN
    // 6. Counter saturation
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd = '1;
    for (int i = 0; i < 70000; i++) begin
      buf_q.push_back(8'($urandom));
      step();
    end
    drain();
    @(negedge clk);
    chk("sent_count_sat", 32'(sent_count), 32'hFFFF);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("sent_count_reset", 32'(sent_count), 32'd0);
    reset = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
